master_port: RTL and testbench
==============================

# master_port

Bus-master side serial port that drives one transaction at a time into a 4 KB block-RAM slave over the system bus. It takes a parallel read or write request from a local master, then runs the valid/ready handshake. It shifts the address and write data out serially, collects serial read data, and reports completion or timeout back to the local master. It is the stage directly upstream of the slave port and connects wire-for-wire to that slave's handshake and serial lines.

## Interface
- ADDR_WIDTH, 12, address bits shifted per transaction
- DATA_WIDTH, 8, data bits per transaction
- TIMEOUT, 255, consecutive no-progress cycles before abort (≥1)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- req  in  1  request strobe, sampled only in IDLE
- req_write  in  1  1 = write, 0 = read; captured with req
- req_address  in  ADDR_WIDTH  target address; captured with req
- req_wdata  in  DATA_WIDTH  write data; captured with req
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle timeout pulse
- rdata  out  DATA_WIDTH  last read result, held until next read completes
- read_en, write_en  out  1  transaction type to slave, held for whole transaction
- master_valid  out  1  master is presenting address/write data
- master_ready  out  1  master is accepting read data
- slave_ready  in  1  slave accepts transaction
- slave_valid  in  1  slave presents a read data bit on rx_data
- slave_rx_done  in  1  slave finished receiving write
- tx_address  out  1  serial address, LSB first
- tx_data  out  1  serial write data, LSB first
- rx_data  in  1  serial read data, LSB first

## Operation
- Reset: all outputs 0, rdata 0, state IDLE, counters 0.
- States:
  - IDLE: on req=1, latch the request and go to REQ. Slave inputs are ignored.
  - REQ: master_valid=1, plus read_en or write_en. Goes to ADDR on slave_ready=1.
  - ADDR: runs ADDR_WIDTH cycles; cycle k drives tx_address=addr[k]. Then goes to WDATA (write) or RDATA (read).
  - WDATA: runs DATA_WIDTH cycles; cycle k drives tx_data=wdata[k]. Then goes to WACK.
  - WACK: master_valid=0. Goes to DONE on slave_rx_done=1.
  - RDATA: master_valid=0, master_ready=1.
    - On each edge where slave_valid=1, rx_data shifts into bit position = bit counter.
    - Gaps with slave_valid=0 are allowed.
    - After DATA_WIDTH bits, rdata updates at the same edge and state goes to DONE.
  - DONE: done=1, read_en/write_en still high. Next state is IDLE.
- tx_address and tx_data are 0 outside ADDR and WDATA respectively.
- req is ignored while busy; no queuing.
- Timeout:
  - The counter clears on every state change and on every accepted read bit.
  - It increments each cycle spent in REQ, WACK or RDATA without progress.
  - When it reaches TIMEOUT: go to IDLE, error=1 for the next cycle, done stays 0, rdata unchanged.
  - Counter width is clog2(TIMEOUT+1).
- All outputs are registered.

## Timing
- Edge 0 samples req; REQ occupies cycle 1.
- With slave_ready=1 at edge 1:
  - ADDR occupies cycles 2..13.
  - Write: WDATA occupies cycles 14..21 and WACK cycle 22. With slave_rx_done=1 at edge 22, done is high in cycle 23.
  - Read: slave_valid high in cycles 14..21 gives done and the new rdata in cycle 22.
- Each extra no-progress cycle adds one cycle of latency.
- Earliest next req is sampled in the first IDLE cycle after DONE, so back-to-back writes start every 24 cycles.
- Reset asserted mid-transaction: outputs drop to 0 asynchronously, and the slave sees master_valid fall.
- After reset release, the first req is sampled on the first rising edge with reset=1.

## Test plan
- Write 0x5A to 0xABC, slave ready immediately -> tx_address shows 0,0,1,1,1,1,0,1,0,1,0,1 in cycles 2..13.
  - tx_data shows 0,1,0,1,1,0,1,0 in cycles 14..21.
  - done pulses in cycle 23 only.
- Read 0x123, slave returns 0xC3 with two 1-cycle gaps in slave_valid -> rdata=0xC3 and done pulse in cycle 24.
  - master_ready high only in RDATA.
- TIMEOUT=4, slave_ready held 0 -> error pulse 5 cycles after REQ entry, no done, busy falls, rdata unchanged.
- Reset pulled low in ADDR cycle 6 -> all outputs 0 within the same cycle.
  - A new write after release completes normally.
- req held high during a write -> the second request is not captured until IDLE.
  - Exactly one done per accepted request; busy falls for one cycle between transactions.
- Read then write back-to-back -> rdata keeps the read value through the write.

Source files
------------

// File: rtl/master_port.sv
// Bus-master serial port: captures one local read/write request, runs the
// valid/ready handshake and shifts address/data to the block-RAM slave.
module master_port #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_address,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  read_en,
   output logic                  write_en,
   output logic                  master_valid,
   output logic                  master_ready,
   input  logic                  slave_ready,
   input  logic                  slave_valid,
   input  logic                  slave_rx_done,
   output logic                  tx_address,
   output logic                  tx_data,
   input  logic                  rx_data
);

   localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int unsigned CNT_W = $clog2(MAX_W);
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_ADDR, S_WDATA, S_WACK, S_RDATA, S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
   logic [DATA_WIDTH-1:0] data_sh_q, data_sh_d;
   logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  read_en_q, read_en_d;
   logic                  write_en_q, write_en_d;
   logic                  mvalid_q, mvalid_d;
   logic                  mready_q, mready_d;
   logic                  tx_addr_q, tx_addr_d;
   logic                  tx_data_q, tx_data_d;
   logic                  tmo_inc;

   // State, datapath and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         tmo_q      <= '0;
         wr_q       <= 1'b0;
         addr_sh_q  <= '0;
         data_sh_q  <= '0;
         rx_sh_q    <= '0;
         rdata_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         read_en_q  <= 1'b0;
         write_en_q <= 1'b0;
         mvalid_q   <= 1'b0;
         mready_q   <= 1'b0;
         tx_addr_q  <= 1'b0;
         tx_data_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         tmo_q      <= tmo_d;
         wr_q       <= wr_d;
         addr_sh_q  <= addr_sh_d;
         data_sh_q  <= data_sh_d;
         rx_sh_q    <= rx_sh_d;
         rdata_q    <= rdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         read_en_q  <= read_en_d;
         write_en_q <= write_en_d;
         mvalid_q   <= mvalid_d;
         mready_q   <= mready_d;
         tx_addr_q  <= tx_addr_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Next state; outputs are decoded from next state so they register in step
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      tmo_d     = tmo_q;
      wr_d      = wr_q;
      addr_sh_d = addr_sh_q;
      data_sh_d = data_sh_q;
      rx_sh_d   = rx_sh_q;
      rdata_d   = rdata_q;
      error_d   = 1'b0;
      tx_addr_d = 1'b0;
      tx_data_d = 1'b0;
      tmo_inc   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               wr_d      = req_write;
               addr_sh_d = req_address;
               data_sh_d = req_wdata;
               state_d   = S_REQ;
            end
         end
         S_REQ: begin
            if (slave_ready) begin
               state_d   = S_ADDR;
               bit_cnt_d = '0;
               tx_addr_d = addr_sh_q[0];
               addr_sh_d = addr_sh_q >> 1;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         S_ADDR: begin
            if (bit_cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
               bit_cnt_d = '0;
               if (wr_q) begin
                  state_d   = S_WDATA;
                  tx_data_d = data_sh_q[0];
                  data_sh_d = data_sh_q >> 1;
               end else begin
                  state_d = S_RDATA;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               tx_addr_d = addr_sh_q[0];
               addr_sh_d = addr_sh_q >> 1;
            end
         end
         S_WDATA: begin
            if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
               bit_cnt_d = '0;
               state_d   = S_WACK;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               tx_data_d = data_sh_q[0];
               data_sh_d = data_sh_q >> 1;
            end
         end
         S_WACK: begin
            if (slave_rx_done) state_d = S_DONE;
            else               tmo_inc = 1'b1;
         end
         S_RDATA: begin
            // LSB arrives first, so shifting in at the top lands it in bit 0
            if (slave_valid) begin
               rx_sh_d = {rx_data, rx_sh_q[DATA_WIDTH-1:1]};
               tmo_d   = '0;
               if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  rdata_d   = rx_sh_d;
                  state_d   = S_DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else begin
               tmo_inc = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (tmo_inc) begin
         if (tmo_q == TMO_W'(TIMEOUT)) begin
            state_d = S_IDLE;
            error_d = 1'b1;
         end else begin
            tmo_d = tmo_q + TMO_W'(1);
         end
      end
      if (state_d != state_q) tmo_d = '0;

      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      read_en_d  = busy_d & ~wr_d;
      write_en_d = busy_d & wr_d;
      mvalid_d   = (state_d == S_REQ) || (state_d == S_ADDR) || (state_d == S_WDATA);
      mready_d   = (state_d == S_RDATA);
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign rdata        = rdata_q;
   assign read_en      = read_en_q;
   assign write_en     = write_en_q;
   assign master_valid = mvalid_q;
   assign master_ready = mready_q;
   assign tx_address   = tx_addr_q;
   assign tx_data      = tx_data_q;

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: per-cycle vector table plus hand-written
// timeout, async-reset and held-request sequences.
module tb_master_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        req, req_write;
   logic [11:0] req_address;
   logic [7:0]  req_wdata;
   logic        busy, done, error;
   logic [7:0]  rdata;
   logic        read_en, write_en, master_valid, master_ready;
   logic        slave_ready, slave_valid, slave_rx_done;
   logic        tx_address, tx_data, rx_data;

   int total = 0;
   int bad   = 0;

   master_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .req(req), .req_write(req_write), .req_address(req_address), .req_wdata(req_wdata),
      .busy(busy), .done(done), .error(error), .rdata(rdata),
      .read_en(read_en), .write_en(write_en),
      .master_valid(master_valid), .master_ready(master_ready),
      .slave_ready(slave_ready), .slave_valid(slave_valid), .slave_rx_done(slave_rx_done),
      .tx_address(tx_address), .tx_data(tx_data), .rx_data(rx_data)
   );

   always #5 clk = ~clk;

   // One record per cycle: inputs held in that cycle, outputs expected in it
   typedef struct {
      logic [1:0]  rqw;   // {req, req_write}
      logic [11:0] a;
      logic [7:0]  wd;
      logic [3:0]  sl;    // {slave_ready, slave_valid, rx_data, slave_rx_done}
      logic [16:0] exp;
   } vec_t;
   vec_t vecs[$];

   // flags = {busy, done, error, master_valid, master_ready, read_en, write_en}
   function automatic logic [16:0] ex(input logic [6:0] flags, input logic ta, input logic td,
                                      input logic [7:0] r);
      return {flags, ta, td, r};
   endfunction

   function automatic logic [16:0] outs();
      return {busy, done, error, master_valid, master_ready, read_en, write_en,
              tx_address, tx_data, rdata};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [1:0] rqw, input logic [11:0] a, input logic [7:0] wd,
                      input logic [3:0] sl, input logic [16:0] exp);
      vec_t v;
      v.rqw = rqw; v.a = a; v.wd = wd; v.sl = sl; v.exp = exp;
      vecs.push_back(v);
   endtask

   // ta/td: bit k is the expected serial bit in the k-th ADDR/WDATA cycle
   task automatic add_write(input logic [11:0] a, input logic [7:0] wd, input logic [11:0] ta,
                            input logic [7:0] td, input logic [7:0] r, input logic nz);
      add(2'b11, a, wd, {1'b0, nz, nz, 1'b0}, ex(7'b0000000, 1'b0, 1'b0, r));
      add(2'b00, '0, '0, {1'b1, nz, nz, 1'b0}, ex(7'b1001001, 1'b0, 1'b0, r));
      for (int k = 0; k < 12; k++)
         add(2'b00, '0, '0, {1'b1, nz, nz, 1'b0}, ex(7'b1001001, ta[k], 1'b0, r));
      for (int k = 0; k < 8; k++)
         add(2'b00, '0, '0, {1'b0, nz, nz, 1'b0}, ex(7'b1001001, 1'b0, td[k], r));
      add(2'b00, '0, '0, {1'b0, nz, nz, 1'b1}, ex(7'b1000001, 1'b0, 1'b0, r));
      add(2'b00, '0, '0, {1'b0, nz, nz, 1'b0}, ex(7'b1100001, 1'b0, 1'b0, r));
   endtask

   task automatic add_read(input logic [11:0] a, input logic [11:0] ta, input logic [9:0] sv,
                           input logic [9:0] rx, input logic [7:0] r_old, input logic [7:0] r_new);
      add(2'b10, a, '0, 4'b0000, ex(7'b0000000, 1'b0, 1'b0, r_old));
      add(2'b00, '0, '0, 4'b1000, ex(7'b1001010, 1'b0, 1'b0, r_old));
      for (int k = 0; k < 12; k++)
         add(2'b00, '0, '0, 4'b1000, ex(7'b1001010, ta[k], 1'b0, r_old));
      for (int j = 0; j < 10; j++)
         add(2'b00, '0, '0, {1'b0, sv[j], rx[j], 1'b0}, ex(7'b1000110, 1'b0, 1'b0, r_old));
      add(2'b00, '0, '0, 4'b0000, ex(7'b1100010, 1'b0, 1'b0, r_new));
   endtask

   initial begin
      int ndone, d1, d2, dcyc, blow;
      logic [11:0] abits;
      logic [7:0]  dbits;

      reset = 1'b0; req = 1'b0; req_write = 1'b0; req_address = '0; req_wdata = '0;
      slave_ready = 1'b0; slave_valid = 1'b0; slave_rx_done = 1'b0; rx_data = 1'b0;

      // 0xABC -> 0,0,1,1,1,1,0,1,0,1,0,1 ; 0x5A -> 0,1,0,1,1,0,1,0
      add_write(12'hABC, 8'h5A, 12'b1010_1011_1100, 8'b0101_1010, 8'h00, 1'b0);
      // 0xC3 LSB first with gaps at the 3rd and 6th RDATA cycles (rx=1 in gaps)
      add_read(12'h123, 12'h123, 10'b11_1101_1011, 10'b11_0010_0111, 8'h00, 8'hC3);
      add_write(12'h801, 8'hF0, 12'h801, 8'hF0, 8'hC3, 1'b1);
      add(2'b00, '0, '0, 4'b0000, ex(7'b0000000, 1'b0, 1'b0, 8'hC3));

      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 32'(outs()), 32'd0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         {req, req_write} = vecs[i].rqw;
         req_address = vecs[i].a;
         req_wdata   = vecs[i].wd;
         {slave_ready, slave_valid, rx_data, slave_rx_done} = vecs[i].sl;
         check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
         tick();
      end

      // Timeout: slave never ready, read request
      req = 1'b1; req_write = 1'b0; req_address = 12'h7FF;
      {slave_ready, slave_valid, rx_data, slave_rx_done} = 4'b0000;
      tick();
      req = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         check($sformatf("tmo_wait%0d", c), 32'({busy, error, master_valid}), 32'(3'b101));
         tick();
      end
      check("tmo_abort", 32'(outs()), 32'(ex(7'b0010000, 1'b0, 1'b0, 8'hC3)));
      tick();
      check("tmo_after", 32'(outs()), 32'(ex(7'b0000000, 1'b0, 1'b0, 8'hC3)));

      // Async reset in ADDR cycle 6
      req = 1'b1; req_write = 1'b1; req_address = 12'h3C5; req_wdata = 8'h96; slave_ready = 1'b1;
      tick();
      req = 1'b0;
      repeat (5) tick();
      check("rst_pre", 32'({busy, master_valid, write_en}), 32'(3'b111));
      reset = 1'b0;
      #1;
      check("rst_async", 32'(outs()), 32'd0);
      tick();
      reset = 1'b1;

      // Fresh write after reset release
      req = 1'b1; req_write = 1'b1; req_address = 12'h0F0; req_wdata = 8'h3C;
      slave_ready = 1'b1; slave_rx_done = 1'b1;
      ndone = 0; dcyc = -1; abits = '0; dbits = '0;
      for (int c = 0; c < 30; c++) begin
         if (c >= 2 && c <= 13) abits[c-2] = tx_address;
         if (c >= 14 && c <= 21) dbits[c-14] = tx_data;
         if (done) begin ndone++; dcyc = c; end
         tick();
         req = 1'b0;
      end
      check("post_rst_addr", 32'(abits), 32'h0F0);
      check("post_rst_data", 32'(dbits), 32'h3C);
      check("post_rst_done_cnt", 32'(ndone), 32'd1);
      check("post_rst_done_cyc", 32'(dcyc), 32'd23);
      check("post_rst_rdata", 32'(rdata), 32'h00);

      // req held high across a whole write
      req = 1'b1; req_write = 1'b1; req_address = 12'h111; req_wdata = 8'h22;
      ndone = 0; d1 = -1; d2 = -1; blow = 0;
      for (int c = 0; c < 52; c++) begin
         if (done) begin
            ndone++;
            if (d1 < 0) d1 = c; else d2 = c;
         end
         if (c >= 1 && c <= 47 && !busy) blow++;
         if (c == 24) check("held_gap", 32'(busy), 32'd0);
         tick();
         if (c == 24) req = 1'b0;
      end
      check("held_done_cnt", 32'(ndone), 32'd2);
      check("held_done1", 32'(d1), 32'd23);
      check("held_done2", 32'(d2), 32'd47);
      check("held_idle_cycles", 32'(blow), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
